// File: rtl/spi_tx_serializer_if.sv
// spi_tx_serializer_if: FIFO read-side and SPI master signals of the serializer.
// master = serializer view, slave = FIFO/SPI-slave/environment view.
interface spi_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  SS_n;
    logic                  SCLK;
    logic                  MOSI;
    logic                  busy;
    logic                  frame_done;
    modport master (
        input  enable, fifo_empty, fifo_data_out,
        output fifo_rd_en, SS_n, SCLK, MOSI, busy, frame_done
    );
    modport slave (
        output enable, fifo_empty, fifo_data_out,
        input  fifo_rd_en, SS_n, SCLK, MOSI, busy, frame_done
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: pops FIFO words and shifts them out MSB-first as SPI mode-0 frames.
// Define SPI_TX_PARITY_EN to append an odd-parity bit (~^data) to every frame.
module spi_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_tx_serializer_if.master bus
);
`ifdef SPI_TX_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(NBITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d, load_word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             rd_en_q, rd_en_d;
    logic             ss_n_q, ss_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             wrap;

`ifdef SPI_TX_PARITY_EN
    assign load_word = {bus.fifo_data_out, ~^bus.fifo_data_out};
`else
    assign load_word = bus.fifo_data_out;
`endif
    assign wrap = cnt_q == CNT_MAX;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rd_en_d = 1'b0;
        ss_n_d  = ss_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                rd_en_d = bus.enable && !bus.fifo_empty;
                state_d = rd_en_d ? FETCH : IDLE;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shreg_d = load_word;
                ss_n_d  = 1'b0;
                mosi_d  = load_word[NBITS-1];
                cnt_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
                if (wrap) begin
                    sclk_d = !sclk_q;
                    // falling SCLK edge: advance to the next bit or close the frame
                    if (sclk_q && bit_q == BIT_MAX) begin
                        ss_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else if (sclk_q) begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_q[NBITS-2];
                    end
                end
            end
            GAP: begin
                cnt_d   = wrap ? '0 : cnt_q + 1'b1;
                state_d = wrap ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        done_d = state_d == GAP && cnt_d == CNT_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            rd_en_q <= 1'b0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            rd_en_q <= rd_en_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= state_d != IDLE;
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.SS_n       = ss_n_q;
    assign bus.SCLK       = sclk_q;
    assign bus.MOSI       = mosi_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_spi_tx_serializer.sv
// tb_spi_tx_serializer: directed bench with a FIFO model, SPI frame monitor and
// expected-word scoreboard; follows SPI_TX_PARITY_EN when it is defined.
module tb_spi_tx_serializer;
`ifdef SPI_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int CD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_tx_serializer_if #(.DATA_WIDTH(8)) bus ();
    spi_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(CD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = wr_ptr == rd_ptr;
    always @(posedge clk)
        if (bus.fifo_rd_en && rd_ptr != wr_ptr) begin
            bus.fifo_data_out <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end

    int cyc = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0, n_fall = 0, rx_n = 0;
    int bits = 0, low = 0;
    logic [8:0] word = '0;
    logic sclk_p = 1'b0, ss_p = 1'b1;
    int fall_t [0:15];
    int rx_bits [0:15];
    int rx_low [0:15];
    int rx_lead [0:15];
    logic [8:0] rx_word [0:15];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            bits = 0;
            word = '0;
            low = 0;
        end else begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.frame_done) done_cnt++;
            if (bus.busy) busy_cnt++;
            if (!bus.SS_n && ss_p) begin
                fall_t[n_fall] = cyc;
                n_fall++;
            end
            if (bus.SCLK && !sclk_p) begin
                if (bits == 0) rx_lead[rx_n] = cyc - fall_t[n_fall-1];
                word = {word[7:0], bus.MOSI};
                bits++;
            end
            if (!bus.SS_n) low++;
            if (bus.SS_n && !ss_p) begin
                rx_word[rx_n] = word;
                rx_bits[rx_n] = bits;
                rx_low[rx_n] = low;
                rx_n++;
                bits = 0;
                word = '0;
                low = 0;
            end
        end
        sclk_p = bus.SCLK;
        ss_p = bus.SS_n;
    end

    int vectors = 0, miscompares = 0, rx_i = 0;
    logic [8:0] exp_q [$];

    function automatic logic [8:0] enc(input logic [7:0] d);
`ifdef SPI_TX_PARITY_EN
        return {d, ~^d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit track);
        mem[wr_ptr] = d;
        wr_ptr++;
        if (track) exp_q.push_back(enc(d));
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t = 0;
        while (rx_n < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, int'(rx_n >= n), 1);
    endtask

    task automatic check_frame(input string tag);
        logic [8:0] e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 9'h1ff;
        chk({tag, "_word"}, int'(rx_word[rx_i]), int'(e));
        chk({tag, "_bits"}, rx_bits[rx_i], NB);
        chk({tag, "_ss_low"}, rx_low[rx_i], 2 * CD * NB);
        chk({tag, "_lead"}, rx_lead[rx_i], CD);
        rx_i++;
    endtask

    initial begin
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", int'(bus.SS_n), 1);
        chk("rst_sclk", int'(bus.SCLK), 0);
        chk("rst_mosi", int'(bus.MOSI), 0);
        chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.frame_done), 0);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        repeat (50) @(negedge clk);
        chk("empty_rd_en", rd_cnt, 0);
        chk("empty_ss_fall", n_fall, 0);
        chk("empty_busy", busy_cnt, 0);
        push(8'hA5, 1'b1);
        wait_rx(1, "a5_timeout");
        repeat (6) @(negedge clk);
        check_frame("a5");
        chk("a5_rd_en", rd_cnt, 1);
        chk("a5_done", done_cnt, 1);
        push(8'h01, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        wait_rx(4, "b2b_timeout");
        repeat (6) @(negedge clk);
        check_frame("b2b0");
        check_frame("b2b1");
        check_frame("b2b2");
        chk("b2b_rd_en", rd_cnt, 4);
        chk("b2b_done", done_cnt, 4);
        chk("b2b_gap01", fall_t[2] - fall_t[1], 2 * CD * NB + CD + 3);
        chk("b2b_gap12", fall_t[3] - fall_t[2], 2 * CD * NB + CD + 3);
        push(8'hA5, 1'b0);
        for (int t = 0; t < 300 && bits < 4; t++) @(negedge clk);
        chk("rst4_rises", bits, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ss_n", int'(bus.SS_n), 1);
        chk("arst_sclk", int'(bus.SCLK), 0);
        chk("arst_mosi", int'(bus.MOSI), 0);
        chk("arst_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst_done", done_cnt, 4);
        chk("arst_no_frame", n_fall, 5);
        chk("arst_rx", rx_n, 4);
        chk("arst_rd_en", rd_cnt, 5);
        push(8'h5A, 1'b1);
        push(8'hC3, 1'b0);
        for (int t = 0; t < 300 && n_fall < 6; t++) @(negedge clk);
        chk("en_drop_start", n_fall, 6);
        bus.enable = 1'b0;
        repeat (120) @(negedge clk);
        chk("en_drop_rx", rx_n, 5);
        check_frame("en_drop");
        chk("en_drop_rd_en", rd_cnt, 6);
        chk("en_drop_done", done_cnt, 5);
        chk("en_drop_left", wr_ptr - rd_ptr, 1);
        chk("en_drop_busy", int'(bus.busy), 0);
        exp_q.push_back(enc(8'hC3));
        bus.enable = 1'b1;
        wait_rx(6, "c3_timeout");
        check_frame("c3");
        push(8'h07, 1'b1);
        wait_rx(7, "x07_timeout");
        repeat (6) @(negedge clk);
        check_frame("x07");
        chk("end_rd_en", rd_cnt, 8);
        chk("end_done", done_cnt, 7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
